multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports clk_i, rst_i.
REQ-002 The block SHALL have these clock/reset ports: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-003 The block SHALL have these inputs: instr_op_i  in  6  opcode from the instruction register; mem_ready_i  in  1  memory access complete this cycle.
REQ-004 The block SHALL have these memory/IR outputs: PCWrite_o  out  1; PCWriteCond_o  out  1; IorD_o  out  1; MemRead_o  out  1; MemWrite_o  out  1; IRWrite_o  out  1.
REQ-005 The block SHALL have these register-file outputs: RegWrite_o  out  1; RegDst_o  out  1; MemtoReg_o  out  1; Jal_o  out  1  (write PC to $31).
REQ-006 The block SHALL have these ALU/PC outputs: ALUSrcA_o  out  1; ALUSrcB_o  out  2  (00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2); ALU_op_o  out  3; PCSource_o  out  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-007 The block SHALL have these status outputs: instr_done_o  out  1  (last-cycle pulse); illegal_o  out  1  (unsupported-opcode pulse); state_o  out  4  (current state).

Function
REQ-008 The block SHALL be a Moore FSM with states IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
REQ-009 Every output not listed for a state SHALL be 0 in that state.
REQ-010 Supported opcodes: R=0, j=2, jal=3, beq=4, bne=5, addi=8, sltiu=9, ori=13, lui=15, lw=35, sw=43.
REQ-011 ALU_op_o encoding: R 000, ori 001, add (addi/lw/sw/PC) 010, bne 011, lui 100, beq 110, sltiu 111.
REQ-012 IDLE: all outputs 0; next state FETCH.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=010, PCSource=00, IRWrite=PCWrite=mem_ready_i; advance to DECODE only when mem_ready_i=1, else hold.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=010.
REQ-015 DECODE dispatch: R->EXEC_R; addi/sltiu/ori/lui->EXEC_I; lw/sw->MEM_ADDR; beq/bne->BRANCH; j/jal->JUMP; any other opcode->FETCH with illegal_o=1 and instr_done_o=1 that cycle.
REQ-016 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=000; then WB_R.
REQ-017 WB_R: RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1; then FETCH.
REQ-018 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_op per REQ-011 for the opcode; then WB_I.
REQ-019 WB_I: RegDst=0, RegWrite=1, instr_done=1; then FETCH.
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=010; lw->MEM_RD, sw->MEM_WR.
REQ-021 MEM_RD: MemRead=1, IorD=1; hold until mem_ready_i=1, then MEM_WB.
REQ-022 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; then FETCH.
REQ-023 MEM_WR: MemWrite=1, IorD=1; when mem_ready_i=1, instr_done=1 and next state FETCH, else hold.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=110 (beq) or 011 (bne), PCWriteCond=1, PCSource=01, instr_done=1; then FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10, instr_done=1; for jal also Jal=1 and RegWrite=1; then FETCH.
REQ-026 instr_op_i SHALL be sampled only in DECODE, EXEC_I, MEM_ADDR, BRANCH and JUMP; the IR holds it stable after FETCH.
REQ-027 Zero-wait latency in cycles from FETCH entry to done SHALL be: R/I 4, lw 5, sw 4, branch 3, jump 3; each mem_ready_i=0 cycle adds one cycle.

Reset
REQ-028 With rst_i=1 at a clock edge, the state SHALL become IDLE from any state, including mid-wait in FETCH/MEM_RD/MEM_WR.
REQ-029 While in IDLE, all outputs SHALL be 0 and state_o SHALL be 0.
REQ-030 No memory strobe or register write SHALL issue in the first cycle after reset deasserts.

Configuration
REQ-031 With MC_CTRL_WAIT_EN defined, mem_ready_i SHALL gate FETCH, MEM_RD and MEM_WR as specified above.
REQ-032 Without MC_CTRL_WAIT_EN, mem_ready_i SHALL be ignored and treated as constant 1, giving fixed latencies.

Structure
REQ-033 Package mc_ctrl_pkg SHALL hold the state encoding (IDLE=0, remainder sequential), the opcode constants, and the ALU_op and PCSource/ALUSrcB constants.
REQ-034 The design SHALL be split into a state register plus next-state logic in multicycle_ctrl, and combinational state-to-control output decode in sub-module mc_ctrl_outdec.

Verification
REQ-035 Reset then op=0, mem_ready=1 -> states IDLE,FETCH,DECODE,EXEC_R,WB_R; RegWrite=1, RegDst=1 in cycle 5; instr_done once.
REQ-036 op=35 with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles; MEM_WB has MemtoReg=1, RegWrite=1; total 7 cycles.
REQ-037 op=5 -> BRANCH with ALU_op=011, PCWriteCond=1, PCSource=01; op=4 -> ALU_op=110.
REQ-038 op=3 -> JUMP with PCWrite=1, PCSource=10, Jal=1, RegWrite=1; op=2 -> same but Jal=0, RegWrite=0.
REQ-039 op=63 -> illegal_o=1 in DECODE, next state FETCH, no RegWrite/MemWrite asserted.
REQ-040 rst_i asserted in MEM_WR with mem_ready=0 -> next cycle IDLE, MemWrite=0; without MC_CTRL_WAIT_EN, sw completes in 4 cycles regardless of mem_ready_i.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, opcode and control-field constants for the multicycle controller.
// Optional memory wait handshake is enabled with the MC_CTRL_WAIT_EN macro (see multicycle_ctrl).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd9;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALU_R     = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_BNE   = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_BEQ   = 3'b110;
    localparam logic [2:0] ALU_SLTIU = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operation for the immediate-format arithmetic instructions
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        logic [2:0] res;
        res = ALU_ADD;
        case (op)
            OP_SLTIU: res = ALU_SLTIU;
            OP_ORI:   res = ALU_OR;
            OP_LUI:   res = ALU_LUI;
            default:  res = ALU_ADD;
        endcase
        return res;
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        logic res;
        res = 1'b0;
        case (op)
            OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
            OP_SLTIU, OP_ORI, OP_LUI, OP_LW, OP_SW: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decode for the multicycle controller.
// ready_i is the effective memory-ready (already forced high when waits are disabled).
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       jal_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        jal_o           = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_REG;
        alu_op_o        = ALU_R;
        pc_source_o     = PCSRC_ALU;
        instr_done_o    = 1'b0;
        illegal_o       = 1'b0;

        case (state_i)
            ST_FETCH: begin
                // PC+4 and the IR load commit only on the cycle memory delivers
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ALU_ADD;
                pc_source_o = PCSRC_ALU;
                ir_write_o  = ready_i;
                pc_write_o  = ready_i;
            end
            ST_DECODE: begin
                alu_src_b_o  = SRCB_IMMSH;
                alu_op_o     = ALU_ADD;
                illegal_o    = ~op_supported(op_i);
                instr_done_o = ~op_supported(op_i);
            end
            ST_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_REG;
                alu_op_o    = ALU_R;
            end
            ST_WB_R: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            ST_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = imm_alu_op(op_i);
            end
            ST_WB_I: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_ADD;
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = ready_i;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = SRCB_REG;
                alu_op_o        = (op_i == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
                instr_done_o    = 1'b1;
            end
            ST_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = PCSRC_JUMP;
                instr_done_o = 1'b1;
                jal_o        = (op_i == OP_JAL);
                reg_write_o  = (op_i == OP_JAL);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: state register and next-state logic.
// Define MC_CTRL_WAIT_EN to let mem_ready_i stall FETCH, MEM_RD and MEM_WR.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       Jal_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALU_op_o,
    output logic [1:0] PCSource_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    state_e state_q;
    state_e state_d;
    logic   ready_eff;

`ifdef MC_CTRL_WAIT_EN
    assign ready_eff = mem_ready_i;
`else
    // Memory is treated as always ready, giving fixed instruction latencies
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign ready_eff        = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ready_eff ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (instr_op_i)
                    OP_R:                           state_d = ST_EXEC_R;
                    OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:                   state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:                 state_d = ST_BRANCH;
                    OP_J, OP_JAL:                   state_d = ST_JUMP;
                    default:                        state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R: state_d = ST_WB_R;
            ST_WB_R:   state_d = ST_FETCH;
            ST_EXEC_I: state_d = ST_WB_I;
            ST_WB_I:   state_d = ST_FETCH;
            ST_MEM_ADDR: begin
                if (instr_op_i == OP_LW) begin
                    state_d = ST_MEM_RD;
                end else if (instr_op_i == OP_SW) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_RD: state_d = ready_eff ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB: state_d = ST_FETCH;
            ST_MEM_WR: state_d = ready_eff ? ST_FETCH : ST_MEM_WR;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign state_o = state_q;

    mc_ctrl_outdec u_outdec (
        .state_i         (state_q),
        .op_i            (instr_op_i),
        .ready_i         (ready_eff),
        .pc_write_o      (PCWrite_o),
        .pc_write_cond_o (PCWriteCond_o),
        .iord_o          (IorD_o),
        .mem_read_o      (MemRead_o),
        .mem_write_o     (MemWrite_o),
        .ir_write_o      (IRWrite_o),
        .reg_write_o     (RegWrite_o),
        .reg_dst_o       (RegDst_o),
        .mem_to_reg_o    (MemtoReg_o),
        .jal_o           (Jal_o),
        .alu_src_a_o     (ALUSrcA_o),
        .alu_src_b_o     (ALUSrcB_o),
        .alu_op_o        (ALU_op_o),
        .pc_source_o     (PCSource_o),
        .instr_done_o    (instr_done_o),
        .illegal_o       (illegal_o)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; expectations follow the build's MC_CTRL_WAIT_EN setting.
module tb_multicycle_ctrl;

`ifdef MC_CTRL_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_WB_R = 4'd4, S_EXEC_I = 4'd5, S_WB_I = 4'd6, S_MEM_ADDR = 4'd7,
                           S_MEM_RD = 4'd8, S_MEM_WB = 4'd9, S_MEM_WR = 4'd10,
                           S_BRANCH = 4'd11, S_JUMP = 4'd12;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       jal;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       done;
        logic       ill;
    } ctrl_t;

    typedef struct {
        int         step;
        logic [3:0] state;
        ctrl_t      ctrl;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] instr_op_i = 6'd0;
    logic       mem_ready_i = 1'b1;
    logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic       RegWrite_o, RegDst_o, MemtoReg_o, Jal_o, ALUSrcA_o;
    logic [1:0] ALUSrcB_o, PCSource_o;
    logic [2:0] ALU_op_o;
    logic       instr_done_o, illegal_o;
    logic [3:0] state_o;
    ctrl_t      obs;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    int   done_seen = 0;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_op_i   (instr_op_i),
        .mem_ready_i  (mem_ready_i),
        .PCWrite_o    (PCWrite_o),
        .PCWriteCond_o(PCWriteCond_o),
        .IorD_o       (IorD_o),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .IRWrite_o    (IRWrite_o),
        .RegWrite_o   (RegWrite_o),
        .RegDst_o     (RegDst_o),
        .MemtoReg_o   (MemtoReg_o),
        .Jal_o        (Jal_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .ALU_op_o     (ALU_op_o),
        .PCSource_o   (PCSource_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
    );

    assign obs = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                  RegWrite_o, RegDst_o, MemtoReg_o, Jal_o, ALUSrcA_o, ALUSrcB_o,
                  ALU_op_o, PCSource_o, instr_done_o, illegal_o};

    // Control table written from the state descriptions; r is the effective ready
    function automatic ctrl_t ref_ctrl(input logic [3:0] s, input logic [5:0] op, input logic r);
        ctrl_t c;
        logic  legal;
        c = '0;
        legal = (op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd13, 6'd15, 6'd35, 6'd43});
        case (s)
            S_FETCH:    begin c.mrd = 1; c.srcb = 2'b01; c.aop = 3'b010; c.irw = r; c.pcw = r; end
            S_DECODE:   begin c.srcb = 2'b11; c.aop = 3'b010; c.ill = !legal; c.done = !legal; end
            S_EXEC_R:   begin c.srca = 1; c.srcb = 2'b00; c.aop = 3'b000; end
            S_WB_R:     begin c.rdst = 1; c.rw = 1; c.done = 1; end
            S_EXEC_I: begin
                c.srca = 1; c.srcb = 2'b10;
                case (op)
                    6'd9:    c.aop = 3'b111;
                    6'd13:   c.aop = 3'b001;
                    6'd15:   c.aop = 3'b100;
                    default: c.aop = 3'b010;
                endcase
            end
            S_WB_I:     begin c.rw = 1; c.done = 1; end
            S_MEM_ADDR: begin c.srca = 1; c.srcb = 2'b10; c.aop = 3'b010; end
            S_MEM_RD:   begin c.mrd = 1; c.iord = 1; end
            S_MEM_WB:   begin c.rw = 1; c.m2r = 1; c.done = 1; end
            S_MEM_WR:   begin c.mwr = 1; c.iord = 1; c.done = r; end
            S_BRANCH: begin
                c.srca = 1; c.pcwc = 1; c.pcs = 2'b01; c.done = 1;
                c.aop = (op == 6'd4) ? 3'b110 : 3'b011;
            end
            S_JUMP: begin
                c.pcw = 1; c.pcs = 2'b10; c.done = 1;
                c.jal = (op == 6'd3); c.rw = (op == 6'd3);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check_front();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty step=%0d observed=0 expected=1", step_no);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (state_o === e.state) else begin
                errors++;
                $error("FAIL state step=%0d observed=%0d expected=%0d", e.step, state_o, e.state);
            end
            checks++;
            assert (obs === e.ctrl) else begin
                errors++;
                $error("FAIL ctrl step=%0d state=%0d observed=%05h expected=%05h",
                       e.step, e.state, obs, e.ctrl);
            end
        end
        if (instr_done_o === 1'b1) done_seen++;
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare mid-cycle
    task automatic step(input logic [5:0] op, input logic rdy, input logic rst, input logic [3:0] exp_state);
        exp_t e;
        rst_i       = rst;
        instr_op_i  = op;
        mem_ready_i = rdy;
        e.step  = step_no;
        e.state = exp_state;
        e.ctrl  = ref_ctrl(exp_state, op, WAIT_EN ? rdy : 1'b1);
        sb.push_back(e);
        @(negedge clk_i);
        check_front();
        step_no++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_done(input string name, input int exp_cnt);
        checks++;
        assert (done_seen === exp_cnt) else begin
            errors++;
            $error("FAIL done_count_%s observed=%0d expected=%0d", name, done_seen, exp_cnt);
        end
        $display("instr %s complete: done pulses=%0d", name, done_seen);
        done_seen = 0;
    endtask

    initial begin
        logic [5:0] iops [4];
        iops = '{6'd8, 6'd9, 6'd13, 6'd15};

        @(posedge clk_i);
        #1;
        step(6'd0, 1'b1, 1'b1, S_IDLE);
        step(6'd0, 1'b1, 1'b0, S_IDLE);
        done_seen = 0;

        // R-type
        step(6'd0, 1'b1, 1'b0, S_FETCH);
        step(6'd0, 1'b1, 1'b0, S_DECODE);
        step(6'd0, 1'b1, 1'b0, S_EXEC_R);
        step(6'd0, 1'b1, 1'b0, S_WB_R);
        check_done("r", 1);

        // I-type arithmetic
        foreach (iops[i]) begin
            step(iops[i], 1'b1, 1'b0, S_FETCH);
            step(iops[i], 1'b1, 1'b0, S_DECODE);
            step(iops[i], 1'b1, 1'b0, S_EXEC_I);
            step(iops[i], 1'b1, 1'b0, S_WB_I);
            check_done("imm", 1);
        end

        // lw with two not-ready cycles in MEM_RD
        step(6'd35, 1'b1, 1'b0, S_FETCH);
        step(6'd35, 1'b1, 1'b0, S_DECODE);
        step(6'd35, 1'b1, 1'b0, S_MEM_ADDR);
        step(6'd35, 1'b0, 1'b0, S_MEM_RD);
        if (WAIT_EN) begin
            step(6'd35, 1'b0, 1'b0, S_MEM_RD);
            step(6'd35, 1'b1, 1'b0, S_MEM_RD);
        end
        step(6'd35, 1'b1, 1'b0, S_MEM_WB);
        check_done("lw", 1);

        // Branches then jumps
        for (int k = 0; k < 4; k++) begin
            logic [5:0] op;
            logic [3:0] st;
            op = (k == 0) ? 6'd5 : (k == 1) ? 6'd4 : (k == 2) ? 6'd3 : 6'd2;
            st = (k < 2) ? S_BRANCH : S_JUMP;
            step(op, 1'b1, 1'b0, S_FETCH);
            step(op, 1'b1, 1'b0, S_DECODE);
            step(op, 1'b1, 1'b0, st);
            check_done("br_jmp", 1);
        end

        // Unsupported opcode
        step(6'd63, 1'b1, 1'b0, S_FETCH);
        step(6'd63, 1'b1, 1'b0, S_DECODE);
        check_done("illegal", 1);

        // sw with memory not ready: FETCH stall, MEM_WR stall, or fixed latency
        step(6'd43, 1'b0, 1'b0, S_FETCH);
        if (WAIT_EN) step(6'd43, 1'b1, 1'b0, S_FETCH);
        step(6'd43, 1'b0, 1'b0, S_DECODE);
        step(6'd43, 1'b0, 1'b0, S_MEM_ADDR);
        step(6'd43, 1'b0, 1'b0, S_MEM_WR);
        if (WAIT_EN) begin
            step(6'd43, 1'b0, 1'b1, S_MEM_WR);
            step(6'd43, 1'b0, 1'b0, S_IDLE);
            check_done("sw_reset", 0);
        end else begin
            check_done("sw_fixed", 1);
            step(6'd43, 1'b0, 1'b0, S_FETCH);
            step(6'd43, 1'b0, 1'b0, S_DECODE);
            step(6'd43, 1'b0, 1'b0, S_MEM_ADDR);
            step(6'd43, 1'b0, 1'b1, S_MEM_WR);
            step(6'd43, 1'b0, 1'b0, S_IDLE);
            done_seen = 0;
        end
        step(6'd0, 1'b1, 1'b0, S_FETCH);
        step(6'd0, 1'b1, 1'b0, S_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
